// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the 1024-point radix-2 FFT frame sequencer:
//   - sequencer state enumeration
//   - transform size constants
//   - default compute-window length (load + all butterfly stages + margin)
// No ports (package).
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_N    = 1024;
    localparam int FFT_LOG2 = 10;

    // Extra cycles after the last butterfly write: AGU pipeline wait plus
    // write drain of the final stage.
    localparam int FFT_DRAIN_MARGIN = 41;

    // Load the whole frame, then FFT_LOG2 stages of FFT_N/2 butterflies each.
    function automatic int fft_cycles(input int n, input int log2n, input int margin);
        return n + log2n * (n / 2) + margin;
    endfunction

    localparam int FFT_CYCLES_DEF = fft_cycles(FFT_N, FFT_LOG2, FFT_DRAIN_MARGIN);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        COMPUTE = 3'd2,
        READOUT = 3'd3,
        DRAIN   = 3'd4
    } fft_state_e;

endpackage

// File: rtl/fft_rd_pipe.sv
// -----------------------------------------------------------------------------
// fft_rd_pipe
// RD_LAT-deep shift register that re-times the result RAM read strobe and the
// "last bin issued" flag so they line up with the RAM's read data.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   issue_i     - a read was issued this cycle
//   last_i      - the read issued this cycle is the final bin of the frame
//   valid_o     - issue_i delayed RD_LAT cycles
//   last_o      - last_i delayed RD_LAT cycles
// -----------------------------------------------------------------------------
module fft_rd_pipe
    import fft_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue_i,
    input  logic last_i,
    output logic valid_o,
    output logic last_o
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] lst_q, lst_d;

    always_comb begin
        vld_d    = vld_q;
        lst_d    = lst_q;
        vld_d[0] = issue_i;
        lst_d[0] = last_i;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            lst_d[i] = lst_q[i-1];
        end
    end

    // Cleared on reset so an aborted frame leaves nothing in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q <= vld_d;
            lst_q <= lst_d;
        end
    end

    assign valid_o = vld_q[RD_LAT-1];
    assign last_o  = lst_q[RD_LAT-1];

endmodule

// File: rtl/fft_frame_sequencer.sv
// -----------------------------------------------------------------------------
// fft_frame_sequencer
// Top-level scheduler for the 1024-point radix-2 FFT engine. Waits for a full
// input frame, pulses the address generator start, times the load plus all
// butterfly stages with a cycle counter, then streams the first OUT_LEN result
// bins out of the result RAM under a ready handshake.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   enable_i        - allows new frames to start (running frame always finishes)
//   frame_ready_i   - level: sample buffer holds a full frame
//   frame_ack_o     - 1-cycle pulse: frame taken, buffer may refill
//   agu_start_o     - 1-cycle start pulse to the address generator
//   busy_o          - high in every state except IDLE
//   rd_addr_o       - result RAM read address (0 outside READOUT)
//   rd_en_o         - result RAM read strobe
//   out_ready_i     - downstream can accept a read issue
//   out_valid_o     - result RAM data valid this cycle
//   out_last_o      - qualifies bin OUT_LEN-1 together with out_valid_o
//   frame_done_o    - 1-cycle pulse after the last bin was valid
//
// Optional build macro FFT_SEQ_OVERRUN_CNT_EN adds:
//   overrun_clr_i   - synchronous clear of the overrun counter (wins)
//   overrun_cnt_o   - saturating count of frame_ready_i rising edges seen
//                     while busy
//
// CNT_W must satisfy 2**CNT_W > FFT_CYCLES; RD_LAT must be at least 1.
// -----------------------------------------------------------------------------
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int FFT_CYCLES = FFT_CYCLES_DEF,
    parameter int OUT_LEN    = 512,
    parameter int ADDR_W     = 10,
    parameter int RD_LAT     = 2,
    parameter int CNT_W      = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              frame_ready_i,
    output logic              frame_ack_o,
    output logic              agu_start_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rd_en_o,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic              out_last_o,
    output logic              frame_done_o
`ifdef FFT_SEQ_OVERRUN_CNT_EN
    ,
    input  logic              overrun_clr_i,
    output logic [15:0]       overrun_cnt_o
`endif
);

    localparam int DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    fft_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DRN_W-1:0]  drn_q, drn_d;
    logic              frame_done_q, frame_done_d;
    logic              issue;
    logic              issue_last;

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_addr_d    = rd_addr_q;
        drn_d        = drn_q;
        frame_done_d = 1'b0;

        issue      = (state_q == READOUT) && out_ready_i;
        issue_last = issue && (rd_addr_q == ADDR_W'(OUT_LEN - 1));

        case (state_q)
            IDLE: begin
                if (enable_i && frame_ready_i) begin
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = COMPUTE;
            end
            COMPUTE: begin
                if (cnt_q == CNT_W'(FFT_CYCLES - 1)) begin
                    cnt_d     = '0;
                    rd_addr_d = '0;
                    state_d   = READOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READOUT: begin
                // Address only advances on an accepted issue; it returns to 0
                // once the final bin has been issued.
                if (issue) begin
                    if (issue_last) begin
                        rd_addr_d = '0;
                        drn_d     = '0;
                        state_d   = DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // DRAIN spans exactly RD_LAT cycles, ending in the cycle the
                // last bin is valid; frame_done is registered so it lands in
                // the following IDLE cycle, where a waiting frame is accepted.
                if (drn_q == DRN_W'(RD_LAT - 1)) begin
                    drn_d        = '0;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rd_addr_q    <= '0;
            drn_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_addr_q    <= rd_addr_d;
            drn_q        <= drn_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_ack_o  = (state_q == START);
    assign agu_start_o  = (state_q == START);
    assign busy_o       = (state_q != IDLE);
    assign rd_addr_o    = rd_addr_q;
    assign rd_en_o      = issue;
    assign frame_done_o = frame_done_q;

    fft_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .issue_i (issue),
        .last_i  (issue_last),
        .valid_o (out_valid_o),
        .last_o  (out_last_o)
    );

`ifdef FFT_SEQ_OVERRUN_CNT_EN
    logic        fr_prev_q, fr_prev_d;
    logic [15:0] ovr_q, ovr_d;
    logic        fr_rise;

    always_comb begin
        fr_prev_d = frame_ready_i;
        fr_rise   = frame_ready_i && !fr_prev_q;
        ovr_d     = ovr_q;
        if (overrun_clr_i) begin
            ovr_d = '0;
        end else if (fr_rise && busy_o && (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fr_prev_q <= 1'b0;
            ovr_q     <= '0;
        end else begin
            fr_prev_q <= fr_prev_d;
            ovr_q     <= ovr_d;
        end
    end

    assign overrun_cnt_o = ovr_q;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_sequencer
// Self-checking bench for fft_frame_sequencer with a short compute window.
// A timeline reference model predicts every output each cycle; scenario
// tables and hand-written sequences cover gating, backpressure, back-to-back
// frames, reset mid-frame and (with FFT_SEQ_OVERRUN_CNT_EN) the overrun count.
// -----------------------------------------------------------------------------
module tb_fft_frame_sequencer;

    localparam int FFT_CYCLES = 20;
    localparam int OUT_LEN    = 8;
    localparam int ADDR_W     = 10;
    localparam int RD_LAT     = 2;
    localparam int CNT_W      = 13;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable_i = 1'b0;
    logic              frame_ready_i = 1'b0;
    logic              out_ready_i = 1'b0;
    logic              ovr_clr = 1'b0;
    logic              frame_ack_o, agu_start_o, busy_o, rd_en_o;
    logic              out_valid_o, out_last_o, frame_done_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [15:0]       overrun_cnt_o;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    fft_frame_sequencer #(
        .FFT_CYCLES (FFT_CYCLES),
        .OUT_LEN    (OUT_LEN),
        .ADDR_W     (ADDR_W),
        .RD_LAT     (RD_LAT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable_i),
        .frame_ready_i (frame_ready_i),
        .frame_ack_o   (frame_ack_o),
        .agu_start_o   (agu_start_o),
        .busy_o        (busy_o),
        .rd_addr_o     (rd_addr_o),
        .rd_en_o       (rd_en_o),
        .out_ready_i   (out_ready_i),
        .out_valid_o   (out_valid_o),
        .out_last_o    (out_last_o),
        .frame_done_o  (frame_done_o)
`ifdef FFT_SEQ_OVERRUN_CNT_EN
        ,
        .overrun_clr_i (ovr_clr),
        .overrun_cnt_o (overrun_cnt_o)
`endif
    );

`ifndef FFT_SEQ_OVERRUN_CNT_EN
    assign overrun_cnt_o = 16'd0;
`endif

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    function automatic logic [31:0] outs_now();
        return {15'd0, frame_ack_o, agu_start_o, busy_o, rd_en_o,
                out_valid_o, out_last_o, frame_done_o, rd_addr_o};
    endfunction

    // ------------------------------------------------------------------
    // Reference model: frame timeline derived from the behaviour rules.
    // A frame accepted in cycle c starts at c+1, reads from start+FFT_CYCLES+1,
    // data appears RD_LAT after each issue, done pulses the cycle after the
    // last bin is valid, and that cycle is idle again.
    // ------------------------------------------------------------------
    int n = 0;
    bit m_active = 0;
    int m_start = 0, m_issued = 0, m_last = -1, m_done = -1;
    int pq_cyc[$];
    bit pq_last[$];
    int m_ovr = 0;
    bit m_prev = 0;

    always @(negedge clk) begin
        bit e_ack, e_busy, e_en, e_val, e_last, e_done;
        int e_addr;
        e_ack = 0; e_busy = 0; e_en = 0; e_val = 0; e_last = 0; e_done = 0; e_addr = 0;
        if (!rst_n) begin
            m_active = 0; m_done = -1; m_issued = 0; m_last = -1;
            pq_cyc.delete(); pq_last.delete();
            m_ovr = 0; m_prev = 0;
        end else begin
            if (pq_cyc.size() > 0 && pq_cyc[0] == n) begin
                e_val  = 1;
                e_last = pq_last[0];
                void'(pq_cyc.pop_front());
                void'(pq_last.pop_front());
            end
            if (m_active) begin
                e_busy = 1;
                if (n == m_start) begin
                    e_ack = 1;
                end else if (n > m_start + FFT_CYCLES && m_issued < OUT_LEN) begin
                    e_en   = out_ready_i;
                    e_addr = m_issued;
                    if (out_ready_i) begin
                        pq_cyc.push_back(n + RD_LAT);
                        pq_last.push_back(m_issued == OUT_LEN - 1);
                        m_issued++;
                        if (m_issued == OUT_LEN) m_last = n;
                    end
                end else if (m_last >= 0 && n == m_last + RD_LAT) begin
                    m_active = 0;
                    m_done   = n + 1;
                end
            end else begin
                e_done = (n == m_done);
                if (enable_i && frame_ready_i) begin
                    m_active = 1; m_start = n + 1; m_issued = 0; m_last = -1;
                end
            end
        end
        check($sformatf("model@%0d", n), outs_now(),
              {15'd0, e_ack, e_ack, e_busy, e_en, e_val, e_last, e_done, ADDR_W'(e_addr)});
`ifdef FFT_SEQ_OVERRUN_CNT_EN
        check($sformatf("ovr_model@%0d", n), {16'd0, overrun_cnt_o}, m_ovr);
        if (rst_n) begin
            if (ovr_clr) m_ovr = 0;
            else if (e_busy && frame_ready_i && !m_prev && m_ovr < 65535) m_ovr++;
            m_prev = frame_ready_i;
        end
`endif
        n++;
    end

    // Drive inputs just after the active edge, return at the following
    // falling edge so callers sample settled outputs.
    task automatic step(input bit en, input bit fr, input bit ordy, input bit clr);
        @(posedge clk);
        #1;
        enable_i = en; frame_ready_i = fr; out_ready_i = ordy; ovr_clr = clr;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy_o && k < 200) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            k++;
        end
        check(name, busy_o, 1'b0);
    endtask

    typedef struct {
        int         en_until;
        int         hold;
        logic [7:0] pat;
        int         exp_starts;
        int         exp_dones;
        int         exp_valids;
    } row_t;

    row_t rows[5];

    initial begin
        int starts, dones, valids, lasts, addr_err, exp_addr, k;
        bit found, fr;

        rows[0] = '{100, 1,   8'hFF,        1, 1, 8};   // single frame, full rate
        rows[1] = '{100, 1,   8'b1001_1001, 1, 1, 8};   // ready 1,0,0,1,...
        rows[2] = '{0,   100, 8'hFF,        0, 0, 0};   // enable low blocks start
        rows[3] = '{100, 40,  8'hFF,        2, 2, 16};  // ready held: two frames
        rows[4] = '{10,  120, 8'hFF,        1, 1, 8};   // enable drops mid-compute

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs_now(), 32'd0);
        check("reset_ovr", {16'd0, overrun_cnt_o}, 32'd0);
        rst_n = 1'b1;

        // Scenario table.
        for (int r = 0; r < 5; r++) begin
            starts = 0; dones = 0; valids = 0; lasts = 0; addr_err = 0; exp_addr = 0;
            for (int c = 0; c < 120; c++) begin
                step(c < rows[r].en_until, c < rows[r].hold, rows[r].pat[c % 8], 1'b0);
                if (agu_start_o) begin starts++; exp_addr = 0; end
                if (rd_en_o) begin
                    if (rd_addr_o != ADDR_W'(exp_addr)) addr_err++;
                    exp_addr++;
                end
                if (out_valid_o) valids++;
                if (out_last_o) lasts++;
                if (frame_done_o) dones++;
            end
            check($sformatf("row%0d_starts", r), starts, rows[r].exp_starts);
            check($sformatf("row%0d_dones", r), dones, rows[r].exp_dones);
            check($sformatf("row%0d_valids", r), valids, rows[r].exp_valids);
            check($sformatf("row%0d_lasts", r), lasts, rows[r].exp_dones);
            check($sformatf("row%0d_addr_order", r), addr_err, 0);
            check($sformatf("row%0d_idle", r), busy_o, 1'b0);
        end

        // Back-to-back: start must follow frame_done by exactly one cycle.
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            if (frame_done_o) found = 1;
        end
        check("b2b_done_seen", found, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("b2b_start", agu_start_o, 1'b1);
        check("b2b_ack", frame_ack_o, 1'b1);
        wait_idle("b2b_idle");

        // Reset mid-frame, while the compute counter reads 10.
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            if (agu_start_o) found = 1;
        end
        check("rst_mid_start_seen", found, 1'b1);
        repeat (10) step(1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", outs_now(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        starts = 0; dones = 0;
        for (int c = 0; c < 40; c++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            if (agu_start_o) starts++;
            if (frame_done_o) dones++;
        end
        check("rst_mid_no_start", starts, 0);
        check("rst_mid_no_done", dones, 0);
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            if (agu_start_o) found = 1;
        end
        check("rst_mid_restart", found, 1'b1);
        wait_idle("rst_mid_idle");

`ifdef FFT_SEQ_OVERRUN_CNT_EN
        // Three frame_ready rising edges during compute, then clear.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("ovr_cleared", {16'd0, overrun_cnt_o}, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("ovr_start", agu_start_o, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, i[0], 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("ovr_three", {16'd0, overrun_cnt_o}, 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("ovr_clear", {16'd0, overrun_cnt_o}, 32'd0);
        wait_idle("ovr_idle");
`endif

        // Random traffic against the reference model.
        fr = 0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) fr = !fr;
            step($urandom_range(0, 9) != 0, fr, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 63) == 0);
        end
        wait_idle("random_idle");

        k = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

endmodule
